// File: rtl/slave_xspi_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : slave_xspi_ctrl_if
// Brief    : PHY-side and memory-side signal bundle of the xSPI slave controller
// Revision : 1.0
// ============================================================================
interface slave_xspi_ctrl_if;
  logic        cs_in;
  logic [1:0]  mode_sel;
  logic [15:0] phy_data;
  logic [15:0] io_out;
  logic        rd_en;
  logic        ds_out;
  logic        sdr_en;
  logic        ddr_1_en;
  logic        ddr_2_en;
  logic [31:0] mem_addr;
  logic        mem_rd_req;
  logic [15:0] mem_rdata;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic        cmd_err;

  modport master (
    output cs_in, mode_sel, phy_data, mem_rdata,
    input  io_out, rd_en, ds_out, sdr_en, ddr_1_en, ddr_2_en,
    input  mem_addr, mem_rd_req, mem_wr_en, mem_wdata, cmd_err
  );

  modport slave (
    input  cs_in, mode_sel, phy_data, mem_rdata,
    output io_out, rd_en, ds_out, sdr_en, ddr_1_en, ddr_2_en,
    output mem_addr, mem_rd_req, mem_wr_en, mem_wdata, cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/slave_xspi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : slave_xspi_ctrl
// Brief    : xSPI slave protocol engine bridging PHY words to a word memory port
// Revision : 1.0
// ============================================================================
module slave_xspi_ctrl #(
  parameter int         DUMMY_CYCLES = 8,
  parameter logic [7:0] OP_READ      = 8'h0B,
  parameter logic [7:0] OP_WRITE     = 8'h02
) (
  input  logic             clk,
  input  logic             reset,
  slave_xspi_ctrl_if.slave bus
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_cmd    = 3'd1;
  localparam logic [2:0] c_st_addr   = 3'd2;
  localparam logic [2:0] c_st_dummy  = 3'd3;
  localparam logic [2:0] c_st_rdata  = 3'd4;
  localparam logic [2:0] c_st_wdata  = 3'd5;
  localparam logic [2:0] c_st_ignore = 3'd6;

  localparam logic [4:0] c_dummy_last = 5'(DUMMY_CYCLES - 1);
  localparam logic [4:0] c_dummy_req  = 5'(DUMMY_CYCLES - 2);

  logic [2:0]  r_state, w_state_next;
  logic [4:0]  r_cnt, w_cnt_next;
  logic        r_is_read, w_is_read_next;
  logic [15:0] r_sh, w_sh_next;
  logic [31:0] r_addr, w_addr_next;
  logic [15:0] r_tx, w_tx_next;
  logic [15:0] r_io, w_io_next;
  logic        r_rd_en, w_rd_en_next;
  logic        r_ds, w_ds_next;
  logic        r_sdr, w_sdr_next;
  logic        r_ddr1, w_ddr1_next;
  logic        r_ddr2, w_ddr2_next;
  logic [31:0] r_mem_addr, w_mem_addr_next;
  logic        r_rd_req, w_rd_req_next;
  logic        r_wr_en, w_wr_en_next;
  logic [15:0] r_wdata, w_wdata_next;
  logic        r_cmd_err, w_cmd_err_next;

  logic        w_ddr;
  logic        w_bit;
  logic [7:0]  w_opcode;
  logic        w_cmd_valid;
  logic        w_last;
  logic [15:0] w_word;

  assign w_ddr       = r_ddr1 | r_ddr2;
  assign w_bit       = bus.phy_data[0];
  assign w_opcode    = w_ddr ? bus.phy_data[15:8] : {r_sh[6:0], w_bit};
  assign w_cmd_valid = (!w_ddr || (bus.phy_data[7:0] == ~bus.phy_data[15:8])) &&
                       ((w_opcode == OP_READ) || (w_opcode == OP_WRITE));

  // Marks the edge that completes the current phase (command, address, dummy or data word)
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      c_st_cmd:   w_last = w_ddr || (r_cnt == 5'd7);
      c_st_addr:  w_last = w_ddr ? (r_cnt == 5'd1) : (r_cnt == 5'd31);
      c_st_dummy: w_last = (r_cnt == c_dummy_last);
      c_st_rdata,
      c_st_wdata: w_last = w_ddr || (r_cnt[3:0] == 4'd15);
      default:    w_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.cs_in) begin
      w_state_next = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:  w_state_next = c_st_cmd;
        c_st_cmd:   if (w_last) w_state_next = w_cmd_valid ? c_st_addr : c_st_ignore;
        c_st_addr:  if (w_last) w_state_next = r_is_read ? c_st_dummy : c_st_wdata;
        c_st_dummy: if (w_last) w_state_next = c_st_rdata;
        default:    w_state_next = r_state;
      endcase
    end
    w_cnt_next = (w_state_next != r_state) ? 5'd0 : r_cnt + 5'd1;
  end

  always_comb begin
    w_word          = w_ddr ? bus.phy_data : {r_sh[14:0], w_bit};
    w_sh_next       = r_sh;
    w_addr_next     = r_addr;
    w_tx_next       = r_tx;
    w_is_read_next  = r_is_read;
    w_io_next       = 16'd0;
    w_rd_en_next    = 1'b0;
    w_ds_next       = 1'b0;
    w_sdr_next      = r_sdr;
    w_ddr1_next     = r_ddr1;
    w_ddr2_next     = r_ddr2;
    w_mem_addr_next = r_mem_addr;
    w_rd_req_next   = 1'b0;
    w_wr_en_next    = 1'b0;
    w_wdata_next    = r_wdata;
    w_cmd_err_next  = 1'b0;
    if (bus.cs_in) begin
      w_sdr_next  = 1'b1;
      w_ddr1_next = 1'b0;
      w_ddr2_next = 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          w_sdr_next  = (bus.mode_sel == 2'b00) || (bus.mode_sel == 2'b11);
          w_ddr1_next = (bus.mode_sel == 2'b01);
          w_ddr2_next = (bus.mode_sel == 2'b10);
        end
        c_st_cmd: begin
          w_sh_next = {r_sh[14:0], w_bit};
          if (w_last) begin
            w_is_read_next = (w_opcode == OP_READ);
            w_cmd_err_next = !w_cmd_valid;
          end
        end
        c_st_addr: begin
          w_addr_next = w_ddr ? {r_addr[15:0], bus.phy_data} : {r_addr[30:0], w_bit};
        end
        c_st_dummy, c_st_rdata: begin
          if (r_state == c_st_rdata || w_last) begin
            w_rd_en_next = 1'b1;
            w_ds_next    = 1'b1;
          end
          // A fresh memory word is taken at dummy end, every DDR beat and after SDR bit 15
          if (w_last) begin
            w_tx_next = bus.mem_rdata;
            w_io_next = w_ddr ? bus.mem_rdata : {14'd0, bus.mem_rdata[15], 1'b0};
          end else if (r_state == c_st_rdata) begin
            w_tx_next = {r_tx[14:0], 1'b0};
            w_io_next = {14'd0, r_tx[14], 1'b0};
          end
        end
        c_st_wdata: begin
          w_sh_next = {r_sh[14:0], w_bit};
          if (w_last) begin
            w_wr_en_next    = 1'b1;
            w_wdata_next    = w_word;
            w_mem_addr_next = r_addr;
            w_addr_next     = r_addr + 32'd1;
          end
        end
        default: ;
      endcase
      // Requests lead their data by one clock; DDR keeps one in flight every beat
      if ((w_state_next == c_st_dummy &&
           (w_cnt_next == c_dummy_req || (w_ddr && w_cnt_next > c_dummy_req))) ||
          (w_state_next == c_st_rdata && (w_ddr || w_cnt_next[3:0] == 4'd14))) begin
        w_rd_req_next   = 1'b1;
        w_mem_addr_next = w_addr_next;
        w_addr_next     = w_addr_next + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_read  <= 1'b0;
      r_sh       <= 16'd0;
      r_addr     <= 32'd0;
      r_tx       <= 16'd0;
      r_io       <= 16'd0;
      r_rd_en    <= 1'b0;
      r_ds       <= 1'b0;
      r_sdr      <= 1'b1;
      r_ddr1     <= 1'b0;
      r_ddr2     <= 1'b0;
      r_mem_addr <= 32'd0;
      r_rd_req   <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wdata    <= 16'd0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_is_read  <= w_is_read_next;
      r_sh       <= w_sh_next;
      r_addr     <= w_addr_next;
      r_tx       <= w_tx_next;
      r_io       <= w_io_next;
      r_rd_en    <= w_rd_en_next;
      r_ds       <= w_ds_next;
      r_sdr      <= w_sdr_next;
      r_ddr1     <= w_ddr1_next;
      r_ddr2     <= w_ddr2_next;
      r_mem_addr <= w_mem_addr_next;
      r_rd_req   <= w_rd_req_next;
      r_wr_en    <= w_wr_en_next;
      r_wdata    <= w_wdata_next;
      r_cmd_err  <= w_cmd_err_next;
    end
  end

  assign bus.io_out     = r_io;
  assign bus.rd_en      = r_rd_en;
  assign bus.ds_out     = r_ds;
  assign bus.sdr_en     = r_sdr;
  assign bus.ddr_1_en   = r_ddr1;
  assign bus.ddr_2_en   = r_ddr2;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_rd_req = r_rd_req;
  assign bus.mem_wr_en  = r_wr_en;
  assign bus.mem_wdata  = r_wdata;
  assign bus.cmd_err    = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_slave_xspi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_xspi_ctrl
// Brief    : directed self-checking bench for slave_xspi_ctrl
// Revision : 1.0
// ============================================================================
module tb_slave_xspi_ctrl;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_wr   = 0;
  int n_rd   = 0;
  int n_cerr = 0;
  int base_wr, base_rd, base_cerr;
  logic [31:0] wr_addr [16];
  logic [15:0] wr_data [16];
  logic [15:0] w0, w1;
  logic        bit_exp;

  slave_xspi_ctrl_if bus ();

  slave_xspi_ctrl #(
    .DUMMY_CYCLES (8),
    .OP_READ      (8'h0B),
    .OP_WRITE     (8'h02)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 16'hBEEF;
      32'h0000_0101: return 16'hCAFE;
      default:       return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  // Memory with a 1-clock read latency
  always @(posedge clk) if (bus.mem_rd_req) bus.mem_rdata <= mem_word(bus.mem_addr);

  always @(negedge clk) begin
    if (bus.mem_wr_en) begin
      if (n_wr < 16) begin
        wr_addr[n_wr[3:0]] = bus.mem_addr;
        wr_data[n_wr[3:0]] = bus.mem_wdata;
      end
      n_wr++;
    end
    if (bus.mem_rd_req) n_rd++;
    if (bus.cmd_err) n_cerr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sdr_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.phy_data = {15'd0, v[i]};
      tick();
    end
  endtask

  task automatic ddr_word(input logic [15:0] w);
    bus.phy_data = w;
    tick();
  endtask

  task automatic start(input logic [1:0] m);
    bus.cs_in    = 1'b0;
    bus.mode_sel = m;
    tick();
  endtask

  task automatic stop();
    bus.cs_in = 1'b1;
    tick();
  endtask

  initial begin
    bus.cs_in    = 1'b1;
    bus.mode_sel = 2'b00;
    bus.phy_data = 16'd0;
    tick();
    chk("rst_sdr_en",  32'(bus.sdr_en), 32'd1);
    chk("rst_ddr1_en", 32'(bus.ddr_1_en), 32'd0);
    chk("rst_rd_en",   32'(bus.rd_en), 32'd0);
    chk("rst_io_out",  32'(bus.io_out), 32'd0);
    chk("rst_wr_en",   32'(bus.mem_wr_en), 32'd0);
    chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // SDR write, two words
    base_wr = n_wr;
    start(2'b00);
    chk("sdr_mode_en", 32'(bus.sdr_en), 32'd1);
    sdr_bits(32'h02, 8);
    sdr_bits(32'h0000_0010, 32);
    sdr_bits(32'hA5C3, 16);
    chk("sdr_wr1_en",   32'(bus.mem_wr_en), 32'd1);
    chk("sdr_wr1_addr", bus.mem_addr, 32'h10);
    chk("sdr_wr1_data", 32'(bus.mem_wdata), 32'hA5C3);
    sdr_bits(32'h1234, 16);
    chk("sdr_wr2_en",   32'(bus.mem_wr_en), 32'd1);
    chk("sdr_wr2_addr", bus.mem_addr, 32'h11);
    chk("sdr_wr2_data", 32'(bus.mem_wdata), 32'h1234);
    stop();
    chk("sdr_wr_end",   32'(bus.mem_wr_en), 32'd0);
    chk("sdr_wr_count", 32'(n_wr - base_wr), 32'd2);
    chk("sdr_wr_log_a", wr_addr[base_wr[3:0]], 32'h10);
    chk("sdr_wr_log_d", 32'(wr_data[base_wr[3:0]]), 32'hA5C3);

    // DDR read: address 0x00000100, two data beats
    start(2'b01);
    chk("ddr_mode_ddr1", 32'(bus.ddr_1_en), 32'd1);
    chk("ddr_mode_sdr",  32'(bus.sdr_en), 32'd0);
    ddr_word(16'h0BF4);
    ddr_word(16'h0000);
    ddr_word(16'h0100);
    for (int d = 0; d < 8; d++) begin
      chk("ddr_dummy_rd_en", 32'(bus.rd_en), 32'd0);
      chk("ddr_dummy_ds",    32'(bus.ds_out), 32'd0);
      chk("ddr_dummy_req",   32'(bus.mem_rd_req), 32'(d >= 6));
      if (d >= 6) chk("ddr_dummy_addr", bus.mem_addr, 32'h100 + 32'(d - 6));
      tick();
    end
    chk("ddr_rd0_rd_en", 32'(bus.rd_en), 32'd1);
    chk("ddr_rd0_ds",    32'(bus.ds_out), 32'd1);
    chk("ddr_rd0_io",    32'(bus.io_out), 32'hBEEF);
    chk("ddr_rd0_req",   32'(bus.mem_rd_req), 32'd1);
    tick();
    chk("ddr_rd1_io",    32'(bus.io_out), 32'hCAFE);
    stop();
    chk("ddr_end_rd_en", 32'(bus.rd_en), 32'd0);
    chk("ddr_end_ds",    32'(bus.ds_out), 32'd0);
    chk("ddr_end_req",   32'(bus.mem_rd_req), 32'd0);
    chk("ddr_end_sdr",   32'(bus.sdr_en), 32'd1);
    chk("ddr_end_ddr1",  32'(bus.ddr_1_en), 32'd0);

    // DDR bad command (inverse mismatch)
    base_wr   = n_wr;
    base_rd   = n_rd;
    base_cerr = n_cerr;
    start(2'b10);
    chk("bad_mode_ddr2", 32'(bus.ddr_2_en), 32'd1);
    ddr_word(16'h0B0B);
    chk("bad_cmd_err", 32'(bus.cmd_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      ddr_word(16'h02FD);
      chk("ign_cmd_err", 32'(bus.cmd_err), 32'd0);
      chk("ign_wr_en",   32'(bus.mem_wr_en), 32'd0);
      chk("ign_rd_req",  32'(bus.mem_rd_req), 32'd0);
    end
    stop();
    chk("bad_err_count", 32'(n_cerr - base_cerr), 32'd1);
    chk("bad_rd_count",  32'(n_rd - base_rd), 32'd0);
    chk("bad_wr_count",  32'(n_wr - base_wr), 32'd0);

    // DDR write across the address wrap
    base_wr = n_wr;
    start(2'b01);
    ddr_word(16'h02FD);
    ddr_word(16'hFFFF);
    ddr_word(16'hFFFF);
    ddr_word(16'h1111);
    chk("wrap_wr1_en",   32'(bus.mem_wr_en), 32'd1);
    chk("wrap_wr1_addr", bus.mem_addr, 32'hFFFF_FFFF);
    chk("wrap_wr1_data", 32'(bus.mem_wdata), 32'h1111);
    ddr_word(16'h2222);
    chk("wrap_wr2_en",   32'(bus.mem_wr_en), 32'd1);
    chk("wrap_wr2_addr", bus.mem_addr, 32'h0000_0000);
    chk("wrap_wr2_data", 32'(bus.mem_wdata), 32'h2222);
    stop();
    chk("wrap_wr_count", 32'(n_wr - base_wr), 32'd2);

    // SDR write aborted after 9 data bits
    base_wr = n_wr;
    start(2'b00);
    sdr_bits(32'h02, 8);
    sdr_bits(32'h0000_0020, 32);
    sdr_bits(32'h1FF, 9);
    stop();
    chk("abort_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("abort_rd_en", 32'(bus.rd_en), 32'd0);
    tick();
    chk("abort_wr_count", 32'(n_wr - base_wr), 32'd0);

    // SDR read from 0x00000200, then async reset mid-RDATA
    w0 = 16'h585A;
    w1 = 16'h585B;
    start(2'b00);
    sdr_bits(32'h0B, 8);
    sdr_bits(32'h0000_0200, 32);
    for (int d = 0; d < 8; d++) begin
      chk("sdr_dummy_req",   32'(bus.mem_rd_req), 32'(d == 6));
      chk("sdr_dummy_rd_en", 32'(bus.rd_en), 32'd0);
      if (d == 6) chk("sdr_dummy_addr", bus.mem_addr, 32'h200);
      tick();
    end
    for (int b = 0; b < 18; b++) begin
      bit_exp = (b < 16) ? w0[15 - b] : w1[31 - b];
      chk("sdr_rd_io",    32'(bus.io_out), 32'({14'd0, bit_exp, 1'b0}));
      chk("sdr_rd_rd_en", 32'(bus.rd_en), 32'd1);
      chk("sdr_rd_req",   32'(bus.mem_rd_req), 32'(b == 14));
      if (b == 14) chk("sdr_rd_req_addr", bus.mem_addr, 32'h201);
      if (b < 17) tick();
    end
    #3;
    reset = 1'b1;
    #1;
    chk("arst_rd_en",  32'(bus.rd_en), 32'd0);
    chk("arst_ds",     32'(bus.ds_out), 32'd0);
    chk("arst_io_out", 32'(bus.io_out), 32'd0);
    chk("arst_sdr_en", 32'(bus.sdr_en), 32'd1);
    bus.cs_in = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Recovery: short DDR write
    start(2'b01);
    ddr_word(16'h02FD);
    ddr_word(16'h0000);
    ddr_word(16'h0005);
    ddr_word(16'h7777);
    chk("rec_wr_en",   32'(bus.mem_wr_en), 32'd1);
    chk("rec_wr_addr", bus.mem_addr, 32'h5);
    chk("rec_wr_data", 32'(bus.mem_wdata), 32'h7777);
    stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/slave_xspi_ctrl.md
Name: slave_xspi_ctrl

Overview:
- Protocol engine directly downstream of the xSPI slave PHY.
- Consumes the PHY's captured 16-bit receive word and chip select, and decodes each transaction: command, 32-bit address, latency, then read or write data.
- Drives the PHY's transmit word, rd_en, ds and SDR/DDR mode enables.
- Bridges transactions to a simple word-wide on-chip memory port with fixed 1-cycle read latency.

Parameters:
- DUMMY_CYCLES, 8: read latency clocks between address and first read data; legal range 2..31.
- OP_READ, 8'h0B: read opcode.
- OP_WRITE, 8'h02: write opcode.

Ports:
- clk  in  1  interface clock, shared with the PHY
- reset  in  1  asynchronous, active-high
- cs_in  in  1  chip select from PHY cs_out, active-low
- mode_sel  in  2  00 SDR, 01 DDR1, 10 DDR2, 11 treated as SDR
- phy_data  in  16  receive word from PHY; SDR uses bit[0], DDR uses [15:0]
- io_out  out  16  transmit word to PHY io_in; SDR drives bit[1], DDR drives [15:0]
- rd_en  out  1  PHY direction control, 1 = slave drives bus
- ds_out  out  1  data strobe to PHY ds_in
- sdr_en, ddr_1_en, ddr_2_en  out  1 each  one-hot mode enables to PHY
- mem_addr  out  32  word address
- mem_rd_req  out  1  read request; mem_rdata valid exactly 1 clk later
- mem_rdata  in  16  read data
- mem_wr_en  out  1  single-cycle write strobe
- mem_wdata  out  16  write data
- cmd_err  out  1  single-cycle pulse on an illegal or corrupt command

Behaviour:
Reset:
- All outputs are 0, except sdr_en=1.
- State is IDLE.
- All outputs are registered.

Mode:
- mode_sel is latched into the mode enables on the first rising edge where cs_in=0 in IDLE.
- The latched mode holds until the transaction ends.
- W = 1 bit per clock in SDR, 16 bits per clock in DDR1/DDR2 (DDR1 and DDR2 behave identically here).

State machine:
- IDLE -> CMD: on the edge where cs_in=0.
- CMD, SDR: 8 clocks, MSB first.
- CMD, DDR: 1 clock; phy_data[15:8] is the opcode and phy_data[7:0] must equal its bitwise inverse.
- Opcode is OP_READ or OP_WRITE -> ADDR.
- Any other opcode, or an inverse mismatch -> IGNORE, with cmd_err pulsed on the following clock.
- ADDR: 32 clocks in SDR, 2 clocks in DDR (upper half first), MSB first.
- After ADDR: read -> DUMMY; write -> WDATA.
- DUMMY: DUMMY_CYCLES clocks; rd_en=0, ds_out=0. In dummy cycle index DUMMY_CYCLES-2: mem_rd_req=1 with mem_addr=captured address.
- End of DUMMY: mem_rdata is loaded into the transmit shifter and the state goes to RDATA.
- RDATA: rd_en=1, ds_out=1.
  - DDR: io_out = one word per clock. mem_rd_req stays high every clock for address+1, +2, …, so data streams without gaps.
  - SDR: io_out[1] shifts the word out MSB first over 16 clocks, and all other io_out bits are 0. mem_rd_req pulses at bit index 14 for the next address; the fetched word is loaded at the end of bit 15.
- WDATA:
  - Bits are assembled MSB first: 16 clocks per word in SDR, 1 clock per word in DDR.
  - On the clock after a word completes: mem_wr_en=1, mem_wdata=word, mem_addr=current address; then the address increments.
- IGNORE: holds with all outputs idle until cs_in=1.

Address:
- Increments by 1 per word.
- Wraps from 32'hFFFF_FFFF to 0.

Transaction end (cs_in=1, any state):
- Next edge: state -> IDLE; rd_en=0, ds_out=0, mem_rd_req=0, sdr_en=1, DDR enables=0.
- A partial write word is discarded; a pending mem_wr_en for an already completed word still issues.
- An in-flight read result is discarded.

Reset mid-transaction:
- Immediate return to the reset values.

Test Plan:
- SDR write: opcode 0x02, address 0x00000010, data bits 0xA5C3 then 0x1234 -> mem_wr_en pulses twice: (0x10, 0xA5C3) then (0x11, 0x1234).
- DDR read, DUMMY_CYCLES=8: word 0x0BF4, address words 0x0000 and 0x0100, memory returns 0xBEEF, 0xCAFE -> mem_rd_req in dummy cycle 6; rd_en and ds_out rise in the 1st data cycle; io_out = 0xBEEF, then 0xCAFE on consecutive clocks.
- DDR bad command: word 0x0B0B -> cmd_err pulses once; no memory access; IGNORE until cs_in=1; the next transaction decodes normally.
- Address wrap: DDR write at 0xFFFFFFFF with two words -> writes go to 0xFFFFFFFF, then 0x00000000.
- Abort: SDR write with cs_in deasserted after 9 data bits -> no mem_wr_en; rd_en=0; state IDLE on the next edge.
- Async reset asserted mid-RDATA between clock edges -> rd_en, ds_out and io_out go to 0 immediately, without waiting for a clock edge.
